// File: rtl/fetch_unit_pkg.sv
// Shared ISA definitions for the fetch stage: widths, opcode field position,
// HALT/NOP encodings and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int INSTR_WIDTH = 16;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;

    localparam logic [ADDR_WIDTH-1:0]  DEF_RESET_PC  = 16'h0000;
    localparam logic [4:0]             DEF_HALT_OPC  = 5'b00000;
    localparam logic [INSTR_WIDTH-1:0] DEF_NOP_INSTR = 16'h0800;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic opc_match(input logic [INSTR_WIDTH-1:0] instr,
                                       input logic [4:0] opc);
        return (instr[OPC_HI:OPC_LO] == opc);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from later stages, instruction memory port and
// the IF/ID pipeline register outputs.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                   stall;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_en;
    logic                   imem_wr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] ifid_instr;
    logic [ADDR_WIDTH-1:0]  ifid_pc;
    logic [ADDR_WIDTH-1:0]  ifid_pc_plus2;
    logic                   ifid_valid;
    logic                   halted;
    logic                   err;
    logic [15:0]            fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_data,
        output imem_addr, imem_en, imem_wr,
        output ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid,
        output halted, err, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_data,
        input  imem_addr, imem_en, imem_wr,
        input  ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid,
        input  halted, err, fetch_count
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with reset value, load port and +2 incrementer.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_VAL = DEF_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  inc_en,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus2
);

    logic [ADDR_WIDTH-1:0] pc_r;

    // 16-bit add wraps 16'hFFFE to 16'h0000 naturally
    assign pc_plus2 = pc_r + 16'd2;
    assign pc       = pc_r;

    // PC update: reset, then load, then increment, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_VAL;
        end else if (load_en) begin
            pc_r <= load_val;
        end else if (inc_en) begin
            pc_r <= pc_plus2;
        end else begin
            pc_r <= pc_r;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the single-cycle instruction memory and
// fills the IF/ID register, honouring stalls, redirects and HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC  = DEF_RESET_PC,
    parameter logic [4:0]             HALT_OPC  = DEF_HALT_OPC,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_e           state_r;
    logic [INSTR_WIDTH-1:0] ifid_instr_r;
    logic [ADDR_WIDTH-1:0]  ifid_pc_r;
    logic [ADDR_WIDTH-1:0]  ifid_pc_plus2_r;
    logic                   ifid_valid_r;
    logic                   err_r;
    logic [15:0]            fetch_count_r;

    logic [ADDR_WIDTH-1:0]  pc_s;
    logic [ADDR_WIDTH-1:0]  pc_plus2_s;
    logic                   pc_inc_s;
    logic                   is_halt_s;

    assign is_halt_s = opc_match(bus.imem_data, HALT_OPC);

    // PC advances only on a real, non-HALT fetch that is not stalled or redirected
    always_comb begin
        pc_inc_s = 1'b0;
        if (!bus.redirect_valid && !bus.stall && (state_r == ST_FETCH) && !is_halt_s) begin
            pc_inc_s = 1'b1;
        end else begin
            pc_inc_s = 1'b0;
        end
    end

    fetch_pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_en  (bus.redirect_valid),
        .load_val ({bus.redirect_pc[ADDR_WIDTH-1:1], 1'b0}),
        .inc_en   (pc_inc_s),
        .pc       (pc_s),
        .pc_plus2 (pc_plus2_s)
    );

    // Fetch FSM, IF/ID register, sticky error and delivered-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_FETCH;
            ifid_instr_r    <= NOP_INSTR;
            ifid_pc_r       <= 16'h0000;
            ifid_pc_plus2_r <= 16'h0002;
            ifid_valid_r    <= 1'b0;
            err_r           <= 1'b0;
            fetch_count_r   <= 16'h0000;
        end else if (bus.redirect_valid) begin
            state_r      <= ST_FETCH;
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
            if (bus.redirect_pc[0]) begin
                err_r <= 1'b1;
            end
        end else if (!bus.stall) begin
            case (state_r)
                ST_FETCH: begin
                    ifid_instr_r    <= bus.imem_data;
                    ifid_pc_r       <= pc_s;
                    ifid_pc_plus2_r <= pc_plus2_s;
                    ifid_valid_r    <= 1'b1;
                    if (fetch_count_r != 16'hFFFF) begin
                        fetch_count_r <= fetch_count_r + 16'd1;
                    end
                    if (is_halt_s) begin
                        state_r <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    ifid_instr_r <= NOP_INSTR;
                    ifid_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_FETCH;
                    ifid_instr_r <= NOP_INSTR;
                    ifid_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Memory is kept disabled during reset so its image can be loaded
    assign bus.imem_addr     = pc_s;
    assign bus.imem_en       = ~rst & (state_r == ST_FETCH);
    assign bus.imem_wr       = 1'b0;
    assign bus.ifid_instr    = ifid_instr_r;
    assign bus.ifid_pc       = ifid_pc_r;
    assign bus.ifid_pc_plus2 = ifid_pc_plus2_r;
    assign bus.ifid_valid    = ifid_valid_r;
    assign bus.halted        = (state_r == ST_HALTED);
    assign bus.err           = err_r;
    assign bus.fetch_count   = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [15:0] mem [0:32767];

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr[15:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        tick();
        tick();
        vectors++; if (bus.imem_en !== 1'b0) begin miscompares++; $display("FAIL rst_imem_en got %b want 0", bus.imem_en); end
        vectors++; if (bus.imem_wr !== 1'b0) begin miscompares++; $display("FAIL rst_imem_wr got %b want 0", bus.imem_wr); end
        vectors++; if (bus.imem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_addr got %h want 0000", bus.imem_addr); end
        vectors++; if (bus.ifid_instr !== 16'h0800) begin miscompares++; $display("FAIL rst_instr got %h want 0800", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc !== 16'h0000) begin miscompares++; $display("FAIL rst_ifid_pc got %h want 0000", bus.ifid_pc); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", bus.ifid_valid); end
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b want 0", bus.halted); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", bus.err); end
        vectors++; if (bus.fetch_count !== 16'h0000) begin miscompares++; $display("FAIL rst_count got %h want 0000", bus.fetch_count); end
        rst = 1'b0;
        #1;
        vectors++; if (bus.imem_en !== 1'b1) begin miscompares++; $display("FAIL post_rst_imem_en got %b want 1", bus.imem_en); end
    endtask

    task automatic test_sequential();
        tick();
        vectors++; if (bus.ifid_instr !== 16'h1111) begin miscompares++; $display("FAIL seq0_instr got %h want 1111", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc !== 16'h0000) begin miscompares++; $display("FAIL seq0_pc got %h want 0000", bus.ifid_pc); end
        vectors++; if (bus.ifid_pc_plus2 !== 16'h0002) begin miscompares++; $display("FAIL seq0_pc2 got %h want 0002", bus.ifid_pc_plus2); end
        vectors++; if (bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL seq0_valid got %b want 1", bus.ifid_valid); end
        vectors++; if (bus.fetch_count !== 16'h0001) begin miscompares++; $display("FAIL seq0_count got %h want 0001", bus.fetch_count); end
        tick();
        vectors++; if (bus.ifid_instr !== 16'h2222) begin miscompares++; $display("FAIL seq1_instr got %h want 2222", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc !== 16'h0002) begin miscompares++; $display("FAIL seq1_pc got %h want 0002", bus.ifid_pc); end
        vectors++; if (bus.imem_addr !== 16'h0004) begin miscompares++; $display("FAIL seq1_addr got %h want 0004", bus.imem_addr); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (bus.ifid_instr !== 16'h2222) begin miscompares++; $display("FAIL stall%0d_instr got %h want 2222", i, bus.ifid_instr); end
            vectors++; if (bus.ifid_pc !== 16'h0002) begin miscompares++; $display("FAIL stall%0d_pc got %h want 0002", i, bus.ifid_pc); end
            vectors++; if (bus.imem_addr !== 16'h0004) begin miscompares++; $display("FAIL stall%0d_addr got %h want 0004", i, bus.imem_addr); end
            vectors++; if (bus.fetch_count !== 16'h0002) begin miscompares++; $display("FAIL stall%0d_count got %h want 0002", i, bus.fetch_count); end
        end
        bus.stall = 1'b0;
        tick();
        vectors++; if (bus.ifid_instr !== 16'h3333) begin miscompares++; $display("FAIL resume_instr got %h want 3333", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc !== 16'h0004) begin miscompares++; $display("FAIL resume_pc got %h want 0004", bus.ifid_pc); end
        vectors++; if (bus.fetch_count !== 16'h0003) begin miscompares++; $display("FAIL resume_count got %h want 0003", bus.fetch_count); end
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        tick();
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid got %b want 0", bus.ifid_valid); end
        vectors++; if (bus.ifid_instr !== 16'h0800) begin miscompares++; $display("FAIL redir_instr got %h want 0800", bus.ifid_instr); end
        vectors++; if (bus.imem_addr !== 16'h0040) begin miscompares++; $display("FAIL redir_addr got %h want 0040", bus.imem_addr); end
        vectors++; if (bus.fetch_count !== 16'h0003) begin miscompares++; $display("FAIL redir_count got %h want 0003", bus.fetch_count); end
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        vectors++; if (bus.ifid_pc !== 16'h0040) begin miscompares++; $display("FAIL redir_tgt_pc got %h want 0040", bus.ifid_pc); end
        vectors++; if (bus.ifid_instr !== 16'h4444) begin miscompares++; $display("FAIL redir_tgt_instr got %h want 4444", bus.ifid_instr); end
        vectors++; if (bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL redir_tgt_valid got %b want 1", bus.ifid_valid); end
    endtask

    task automatic test_halt();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0006;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        vectors++; if (bus.ifid_instr[15:11] !== 5'b00000) begin miscompares++; $display("FAIL halt_opc got %b want 00000", bus.ifid_instr[15:11]); end
        vectors++; if (bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL halt_valid got %b want 1", bus.ifid_valid); end
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL halt_halted got %b want 1", bus.halted); end
        vectors++; if (bus.imem_en !== 1'b0) begin miscompares++; $display("FAIL halt_en got %b want 0", bus.imem_en); end
        vectors++; if (bus.fetch_count !== 16'h0005) begin miscompares++; $display("FAIL halt_count got %h want 0005", bus.fetch_count); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL drain%0d_valid got %b want 0", i, bus.ifid_valid); end
            vectors++; if (bus.ifid_instr !== 16'h0800) begin miscompares++; $display("FAIL drain%0d_instr got %h want 0800", i, bus.ifid_instr); end
            vectors++; if (bus.imem_addr !== 16'h0006) begin miscompares++; $display("FAIL drain%0d_addr got %h want 0006", i, bus.imem_addr); end
            vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL drain%0d_halted got %b want 1", i, bus.halted); end
            vectors++; if (bus.fetch_count !== 16'h0005) begin miscompares++; $display("FAIL drain%0d_count got %h want 0005", i, bus.fetch_count); end
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0010;
        tick();
        bus.redirect_valid = 1'b0;
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL unhalt_halted got %b want 0", bus.halted); end
        vectors++; if (bus.imem_en !== 1'b1) begin miscompares++; $display("FAIL unhalt_en got %b want 1", bus.imem_en); end
        vectors++; if (bus.imem_addr !== 16'h0010) begin miscompares++; $display("FAIL unhalt_addr got %h want 0010", bus.imem_addr); end
        tick();
        vectors++; if (bus.ifid_instr !== 16'h5555) begin miscompares++; $display("FAIL unhalt_instr got %h want 5555", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc !== 16'h0010) begin miscompares++; $display("FAIL unhalt_pc got %h want 0010", bus.ifid_pc); end
        vectors++; if (bus.fetch_count !== 16'h0006) begin miscompares++; $display("FAIL unhalt_count got %h want 0006", bus.fetch_count); end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        tick();
        bus.redirect_valid = 1'b0;
        vectors++; if (bus.imem_addr !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_addr0 got %h want fffe", bus.imem_addr); end
        tick();
        vectors++; if (bus.ifid_pc !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_pc got %h want fffe", bus.ifid_pc); end
        vectors++; if (bus.ifid_pc_plus2 !== 16'h0000) begin miscompares++; $display("FAIL wrap_pc2 got %h want 0000", bus.ifid_pc_plus2); end
        vectors++; if (bus.ifid_instr !== 16'h6666) begin miscompares++; $display("FAIL wrap_instr got %h want 6666", bus.ifid_instr); end
        vectors++; if (bus.imem_addr !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr1 got %h want 0000", bus.imem_addr); end
        tick();
        vectors++; if (bus.ifid_instr !== 16'h1111) begin miscompares++; $display("FAIL wrap_next_instr got %h want 1111", bus.ifid_instr); end
        vectors++; if (bus.fetch_count !== 16'h0008) begin miscompares++; $display("FAIL wrap_count got %h want 0008", bus.fetch_count); end
    endtask

    task automatic test_misaligned();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0011;
        tick();
        bus.redirect_valid = 1'b0;
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL mis_err got %b want 1", bus.err); end
        vectors++; if (bus.imem_addr !== 16'h0010) begin miscompares++; $display("FAIL mis_addr got %h want 0010", bus.imem_addr); end
        tick();
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL mis_sticky got %b want 1", bus.err); end
        vectors++; if (bus.ifid_instr !== 16'h5555) begin miscompares++; $display("FAIL mis_instr got %h want 5555", bus.ifid_instr); end
        vectors++; if (bus.fetch_count !== 16'h0009) begin miscompares++; $display("FAIL mis_count got %h want 0009", bus.fetch_count); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        vectors++; if (bus.imem_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_en got %b want 0", bus.imem_en); end
        tick();
        vectors++; if (bus.imem_addr !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_addr got %h want 0000", bus.imem_addr); end
        vectors++; if (bus.ifid_instr !== 16'h0800) begin miscompares++; $display("FAIL mid_rst_instr got %h want 0800", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_pc got %h want 0000", bus.ifid_pc); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", bus.ifid_valid); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err got %b want 0", bus.err); end
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL mid_rst_halted got %b want 0", bus.halted); end
        vectors++; if (bus.fetch_count !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_count got %h want 0000", bus.fetch_count); end
        rst = 1'b0;
        tick();
        vectors++; if (bus.ifid_instr !== 16'h1111) begin miscompares++; $display("FAIL post_mid_instr got %h want 1111", bus.ifid_instr); end
        vectors++; if (bus.fetch_count !== 16'h0001) begin miscompares++; $display("FAIL post_mid_count got %h want 0001", bus.fetch_count); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'h0800;
        end
        mem[0]        = 16'h1111;
        mem[1]        = 16'h2222;
        mem[2]        = 16'h3333;
        mem[3]        = 16'h0000;
        mem[8]        = 16'h5555;
        mem[32]       = 16'h4444;
        mem[32767]    = 16'h6666;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_wrap();
        test_misaligned();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
